// File: rtl/par_ser_conv_32.sv
// -----------------------------------------------------------------------------
// par_ser_conv_32
//
// Parallel-to-serial converter: the transmit end of the single-bit serial link.
// A WIDTH-bit word is taken through a ready/load handshake and shifted out one
// bit per clock, LSB first, with a bit-valid strobe. o_ser_out/o_ser_valid feed
// the data/enable inputs of the 32-bit serial-to-parallel converter. Words may
// stream back to back with no idle gap.
//
// State table:
//   S_IDLE  | no word in flight; ready high, ser_valid low, registers held
//   S_SHIFT | word in flight; cnt is the index of the bit now on o_ser_out
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   i_data_in    in   WIDTH  parallel word, sampled only on an accepted load
//   i_load       in   1      word-valid request from the producer
//   o_ready      out  1      a load this cycle will be accepted
//   o_ser_out    out  1      serial bit (shift register bit 0)
//   o_ser_valid  out  1      o_ser_out carries a valid bit this cycle
//   o_last       out  1      the current valid bit is bit WIDTH-1 of the word
// -----------------------------------------------------------------------------
module par_ser_conv_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_load,
    output logic             o_ready,
    output logic             o_ser_out,
    output logic             o_ser_valid,
    output logic             o_last
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_cnt_last;
    logic               w_accept;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Outputs are decoded straight from registers so the handshake is not
    // pipelined: ready during the last bit lets the next word follow seamlessly.
    assign o_ser_valid = (r_state == S_SHIFT);
    assign o_ready     = (r_state == S_IDLE) || ((r_state == S_SHIFT) && w_cnt_last);
    assign o_last      = o_ser_valid && w_cnt_last;
    assign o_ser_out   = r_shreg[0];

    assign w_accept    = i_load && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= i_data_in;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!w_cnt_last) begin
                        // Mid-word: load is ignored, nothing is queued.
                        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else if (w_accept) begin
                        r_shreg <= i_data_in;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        // Final shift empties the register so ser_out idles at 0.
                        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_shreg <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_ser_conv_32.sv
// -----------------------------------------------------------------------------
// tb_par_ser_conv_32
//
// Directed bench for par_ser_conv_32. Inputs are driven and outputs sampled on
// the falling clock edge, away from the rising edge that updates the design.
// A serial-to-parallel receiver model rebuilds words during the loopback run.
// -----------------------------------------------------------------------------
module tb_par_ser_conv_32;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        load;
    logic        ready;
    logic        ser_out;
    logic        ser_valid;
    logic        last;

    int n_vec = 0;
    int n_err = 0;

    par_ser_conv_32 #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data_in   (data_in),
        .i_load      (load),
        .o_ready     (ready),
        .o_ser_out   (ser_out),
        .o_ser_valid (ser_valid),
        .o_last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ser_valid"}, {31'd0, ser_valid}, 32'd0);
        chk({tag, ".ser_out"},   {31'd0, ser_out},   32'd0);
        chk({tag, ".last"},      {31'd0, last},      32'd0);
        chk({tag, ".ready"},     {31'd0, ready},     32'd1);
    endtask

    // Called at the falling edge of valid cycle 1 of word w. Checks all 32
    // cycles and leaves the bench at the falling edge after the last bit.
    // If chain is set, nxt is loaded during the last cycle. During valid
    // cycles busy_lo..busy_hi an all-ones word is offered and must be ignored.
    task automatic expect_word(input string tag, input logic [31:0] w,
                               input logic chain, input logic [31:0] nxt,
                               input int busy_lo, input int busy_hi);
        logic [31:0] wv;
        wv = w;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s.valid[%0d]", tag, i), {31'd0, ser_valid}, 32'd1);
            chk($sformatf("%s.bit[%0d]", tag, i),   {31'd0, ser_out},   {31'd0, wv[i]});
            chk($sformatf("%s.last[%0d]", tag, i),  {31'd0, last},      {31'd0, (i == 31)});
            chk($sformatf("%s.ready[%0d]", tag, i), {31'd0, ready},     {31'd0, (i == 31)});
            if (chain && i == 31) begin
                load    = 1'b1;
                data_in = nxt;
            end else if ((i + 1) >= busy_lo && (i + 1) <= busy_hi) begin
                load    = 1'b1;
                data_in = 32'hFFFF_FFFF;
            end else begin
                load    = 1'b0;
                data_in = 32'h0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    // Receiver model: right-shifting, fills from the MSB, word complete after
    // 32 valid bits. Only active while rx_on is set.
    logic        rx_on = 1'b0;
    logic [31:0] rx_sh = 32'd0;
    int          rx_cnt = 0;
    logic [31:0] rxq[$];

    always @(negedge clk) begin
        if (rst) begin
            rx_cnt = 0;
        end else if (rx_on && ser_valid) begin
            chk($sformatf("rx.last[%0d]", rx_cnt), {31'd0, last}, {31'd0, (rx_cnt == 31)});
            rx_sh = {ser_out, rx_sh[31:1]};
            if (rx_cnt == 31) begin
                rxq.push_back(rx_sh);
                rx_cnt = 0;
            end else begin
                rx_cnt = rx_cnt + 1;
            end
        end
    end

    logic [31:0] lb_word[100];
    int          lb_gap[100];
    logic [31:0] rx_val;

    initial begin
        rst     = 1'b0;
        load    = 1'b0;
        data_in = 32'h0;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 chk_idle("reset_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        // Single word, then idle.
        load = 1'b1; data_in = 32'h8000_0001;
        @(negedge clk);
        load = 1'b0; data_in = 32'h0;
        expect_word("single", 32'h8000_0001, 1'b0, 32'h0, 0, -1);
        chk_idle("single_end");

        // Back-to-back pair with no idle gap.
        load = 1'b1; data_in = 32'hDEAD_BEEF;
        @(negedge clk);
        load = 1'b0;
        expect_word("b2b_a", 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 0, -1);
        expect_word("b2b_b", 32'h1234_5678, 1'b0, 32'h0, 0, -1);
        chk_idle("b2b_end");

        // Loads offered mid-word are ignored.
        load = 1'b1; data_in = 32'hA5A5_A5A5;
        @(negedge clk);
        load = 1'b0;
        expect_word("busy", 32'hA5A5_A5A5, 1'b0, 32'h0, 5, 20);
        chk_idle("busy_end");

        // Reset in the middle of a word, then a fresh word.
        load = 1'b1; data_in = 32'hCAFE_F00D;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("cafe.bit[%0d]", i), {31'd0, ser_out}, {31'd0, ((32'hCAFE_F00D >> i) & 32'd1) == 32'd1});
            if (i < 9) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 chk_idle("reset_mid");
        @(negedge clk);
        chk_idle("reset_hold");
        rst = 1'b0; load = 1'b1; data_in = 32'h0000_00FF;
        @(negedge clk);
        load = 1'b0; data_in = 32'h0;
        expect_word("after_rst", 32'h0000_00FF, 1'b0, 32'h0, 0, -1);
        chk_idle("after_rst_end");

        // Loopback of 100 random words with 0-3 idle cycles between them.
        for (int n = 0; n < 100; n++) begin
            lb_word[n] = $urandom;
            lb_gap[n]  = int'($urandom_range(0, 3));
        end
        rxq.delete();
        rx_on = 1'b1;
        load = 1'b1; data_in = lb_word[0];
        @(negedge clk);
        load = 1'b0;
        for (int n = 0; n < 100; n++) begin
            repeat (31) @(negedge clk);
            if (n < 99) begin
                if (lb_gap[n+1] == 0) begin
                    load = 1'b1; data_in = lb_word[n+1];
                    @(negedge clk);
                    load = 1'b0;
                end else begin
                    @(negedge clk);
                    repeat (lb_gap[n+1] - 1) @(negedge clk);
                    load = 1'b1; data_in = lb_word[n+1];
                    @(negedge clk);
                    load = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        rx_on = 1'b0;
        chk_idle("loop_end");
        chk("loop.count", rxq.size(), 32'd100);
        for (int n = 0; n < 100; n++) begin
            rx_val = (n < rxq.size()) ? rxq[n] : 32'hXXXX_XXXX;
            chk($sformatf("loop.word[%0d]", n), rx_val, lb_word[n]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/par_ser_conv_32.md
# par_ser_conv_32

Parallel-to-serial converter. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out one bit per clock, LSB first, with a bit-valid strobe. It is the transmit end of the single-bit serial link whose receive end is the team's 32-bit serial-to-parallel converter: `ser_out` drives that converter's data input and `ser_valid` drives its enable. Back-to-back words stream with no idle gap between them.

## Interface
- `WIDTH`, default 32: word length in bits; must be ≥ 2.
- `CNT_W`, default 5: bit-counter width, equal to $clog2(WIDTH).
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `data_in`  in  WIDTH: parallel word; sampled only on an accepted load.
- `load`  in  1: word-valid request from the upstream producer.
- `ready`  out  1: converter can accept a word this cycle.
- `ser_out`  out  1: serial data bit, always equal to `shreg[0]`.
- `ser_valid`  out  1: `ser_out` carries a valid bit this cycle.
- `last`  out  1: the current valid bit is bit WIDTH-1 of the word.

## Operation
- Internal state:
  - FSM with states S_IDLE and S_SHIFT.
  - Shift register `shreg[WIDTH-1:0]`.
  - Bit counter `cnt[CNT_W-1:0]`.
- Combinational outputs:
  - `ready` = (state == S_IDLE) || (state == S_SHIFT && cnt == WIDTH-1).
  - `ser_valid` = (state == S_SHIFT).
  - `last` = `ser_valid` && (cnt == WIDTH-1).
- Accept: `load && ready` at a rising edge does all of the following:
  - `shreg <= data_in`
  - `cnt <= 0`
  - `state <= S_SHIFT`
- S_IDLE:
  - With no load: hold all registers; `ser_valid` stays 0.
- S_SHIFT with cnt < WIDTH-1:
  - `shreg <= {1'b0, shreg[WIDTH-1:1]}`
  - `cnt <= cnt + 1`
  - `load` is ignored and `data_in` is not sampled. No error is flagged and no word is queued.
- S_SHIFT with cnt == WIDTH-1 (last bit on the line):
  - With `load`: reload as in Accept and stay in S_SHIFT. This is the seamless back-to-back case.
  - Without `load`: `state <= S_IDLE` and `cnt <= 0`. `shreg` shifts once more, leaving all zeros.
- Bit order: bit i of the word is driven during the i-th valid cycle of that word, i = 0..WIDTH-1. A right-shifting receiver that fills from the MSB therefore reconstructs the word exactly.
- Counter wrap: `cnt` never exceeds WIDTH-1. It returns to 0 on reload or on exit to idle; there is no modulo-2^CNT_W wrap.
- Reset, including mid-word:
  - `state` = S_IDLE, `shreg` = 0, `cnt` = 0.
  - Resulting outputs: `ser_out` = 0, `ser_valid` = 0, `last` = 0, `ready` = 1.
  - A partially sent word is dropped and is not resumed after reset.

## Timing
- `load` is accepted at edge k.
- Word bits appear during cycles k+1 .. k+WIDTH (cycle n is the period after edge n):
  - bit 0 during cycle k+1;
  - bit i during cycle k+1+i;
  - `last` = 1 during cycle k+WIDTH.
- Latency from accepted load to first valid bit: 1 cycle.
- `ready` timing:
  - high during cycle k+WIDTH, so a load at edge k+WIDTH puts the next word's bit 0 in cycle k+WIDTH+1;
  - low during cycles k+1 .. k+WIDTH-1.
- Throughput: one bit per clock sustained.
- Idle gap between words: minimum 0 cycles; with S_IDLE entered, at least 1 cycle.
- `load` asserted in the same cycle that `rst` deasserts is accepted at the first rising edge with `rst` low.
- `load` in S_IDLE with `ready` = 1 is accepted at that edge. `ready` is not pipelined.

## Test plan
- Reset values: assert `rst` asynchronously mid-cycle -> `ser_valid` = 0, `ser_out` = 0, `last` = 0, `ready` = 1 immediately, without waiting for a clock edge.
- Single word: load 32'h8000_0001 once, then hold `load` low ->
  - valid cycles 1..32 carry 1, 0×30, 1;
  - `last` high only on cycle 32;
  - `ser_valid` = 0 from cycle 33 and `ready` = 1 again.
- Back-to-back: load 32'hDEAD_BEEF, keep `load` high, present 32'h1234_5678 at the `last` cycle ->
  - 64 contiguous valid cycles;
  - LSB-first bit streams match both words exactly;
  - `last` pulses on cycles 32 and 64.
- Busy-ignore: after loading 32'hA5A5_A5A5, pulse `load` with 32'hFFFF_FFFF during cycles 5..20 -> output stream is still A5A5_A5A5 and `ready` stays low throughout the pulse.
- Reset mid-word: assert `rst` at cycle 10 of 32'hCAFE_F00D, release, then load 32'h0000_00FF ->
  - no remnant bits of the first word appear;
  - the new word is serialized correctly starting 1 cycle after the load edge.
- Loopback: drive 100 random words with random 0-3 cycle idle gaps into a serial-to-parallel bench model fed by `ser_out` and `ser_valid` -> every reconstructed word equals the loaded word, in order.
